// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache controller: field widths, tag bit layout, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_pkg;

    localparam int TAG_W     = 23;
    localparam int IDX_W     = 4;
    localparam int LINE_W    = 256;
    localparam int WORD_W    = 32;
    localparam int SEL_W     = 3;
    localparam int OFF_W     = 5;
    localparam int STAG_W    = TAG_W + 2;

    // Stored tag layout: {valid, dirty, tag[22:0]}
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

endpackage

// File: rtl/dcache_word_merge.sv
// Inserts a 32-bit word into a 256-bit line and extracts the selected word.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [SEL_W-1:0]  sel,
    input  logic [WORD_W-1:0] wdata,
    output logic [LINE_W-1:0] merged,
    output logic [WORD_W-1:0] rdata
);

    logic [7:0] bit_off;

    assign bit_off = {sel, 5'b0};

    // Overwrite the selected word; every other word passes through
    always_comb begin
        merged                    = line;
        merged[bit_off +: WORD_W] = wdata;
    end

    assign rdata = line[bit_off +: WORD_W];

endmodule

// File: rtl/dcache_controller.sv
// 2-way write-back/write-allocate dcache controller between CPU memory stage, tag/data SRAM and memory.
// Latency: hits complete in the request cycle; clean miss stalls 4 + memory latency cycles, dirty miss adds a write-back.
// Backpressure: cpu_stall_o holds the CPU on any miss; mem_enable_o stays high as a level until mem_ack_i.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [WORD_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
    output logic [IDX_W-1:0]  sram_addr_o,
    output logic [STAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0] sram_data_o,
    output logic              sram_enable_o,
    output logic              sram_write_o,
    input  logic [STAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    input  logic              sram_hit_i,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    state_t            state;
    state_t            state_nxt;

    logic              req;
    logic              hit_idle;
    logic              victim_dirty;
    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  cpu_idx;
    logic [SEL_W-1:0]  cpu_sel;
    logic [31:0]       refill_addr;
    logic [31:0]       victim_addr;
    logic [LINE_W-1:0] merged_line;
    logic [WORD_W-1:0] hit_word;
    logic              unused_addr_bits;

    assign cpu_tag          = cpu_addr_i[31:9];
    assign cpu_idx          = cpu_addr_i[8:5];
    assign cpu_sel          = cpu_addr_i[4:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // A simultaneous read and write is handled as a write, so only the write strobe matters below
    assign req          = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit_idle     = (state == IDLE) & sram_hit_i;
    assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

    assign refill_addr  = {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
    assign victim_addr  = {sram_tag_i[TAG_W-1:0], cpu_idx, {OFF_W{1'b0}}};

    assign sram_addr_o   = cpu_idx;
    assign sram_enable_o = req;
    assign cpu_stall_o   = req & ~hit_idle;
    assign cpu_data_o    = (req & hit_idle) ? hit_word : '0;

    dcache_word_merge u_word_merge (
        .line   (sram_data_i),
        .sel    (cpu_sel),
        .wdata  (cpu_data_i),
        .merged (merged_line),
        .rdata  (hit_word)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a miss walks MISS -> (WRITEBACK) -> READMISS -> READMISSOK -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (req & ~sram_hit_i) state_nxt = MISS;
            MISS:       state_nxt = victim_dirty ? WRITEBACK : READMISS;
            WRITEBACK:  if (mem_ack_i) state_nxt = READMISS;
            READMISS:   if (mem_ack_i) state_nxt = READMISSOK;
            READMISSOK: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // SRAM write path: merge a store on an IDLE hit, install the refill line on the read ack
    always_comb begin
        sram_write_o = 1'b0;
        sram_data_o  = '0;
        sram_tag_o   = {1'b0, 1'b0, cpu_tag};
        if ((state == IDLE) & req & sram_hit_i & cpu_MemWrite_i) begin
            sram_write_o = 1'b1;
            sram_data_o  = merged_line;
            sram_tag_o   = {1'b1, 1'b1, cpu_tag};
        end else if ((state == READMISS) & mem_ack_i) begin
            sram_write_o = 1'b1;
            sram_data_o  = mem_data_i;
            sram_tag_o   = {1'b1, 1'b0, cpu_tag};
        end
    end

    // Memory request registers: issued in MISS, retargeted to the refill after a write-back ack
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (victim_dirty) begin
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= victim_addr;
                        mem_data_o  <= sram_data_i;
                    end else begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= refill_addr;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= refill_addr;
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic         cpu_MemRead_i = 1'b0;
    logic         cpu_MemWrite_i = 1'b0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int stray_req = 0;

    typedef struct { bit st; logic [31:0] addr; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; logic wr; } txn_t;
    exp_t sb[$];
    txn_t mlog[$];

    // Flat reference memory (word granularity) and the backing line store of the memory model
    logic [31:0]  ref_mem [bit [31:0]];
    logic [255:0] bmem    [bit [31:0]];

    // Behavioural 2-way SRAM: tags, lines, and per-set way to evict next
    bit [24:0]  tg [16][2];
    bit [255:0] dt [16][2];
    bit         lru [16];
    bit         sram_way;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_enable_o(mem_enable_o),
        .mem_write_o(mem_write_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
        return init_word({a[31:2], 2'b00});
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word({a[31:5], 5'b0} + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        if (bmem.exists(a >> 5)) return bmem[a >> 5];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({a[31:5], 5'b0} + 32'(w * 4));
        return l;
    endfunction

    // Stall cycles expected from the SRAM model's current contents
    function automatic int predict(input logic [31:0] a);
        int ix;
        bit v;
        ix = int'(a[8:5]);
        for (int w = 0; w < 2; w++)
            if (tg[ix][w][24] && tg[ix][w][22:0] == a[31:9]) return 0;
        v = lru[ix];
        if (tg[ix][v][24] && tg[ix][v][23]) return 5 + 2 * mem_lat;
        return 4 + mem_lat;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic poke_word(input logic [31:0] a, input logic [31:0] v);
        logic [255:0] l;
        l = mem_line(a);
        l[int'(a[4:2])*32 +: 32] = v;
        bmem[a >> 5] = l;
        ref_mem[a >> 2] = v;
    endtask

    // SRAM lookup: tag match in either way, otherwise present the LRU victim
    always_comb begin
        sram_hit_i = 1'b0;
        sram_way   = lru[sram_addr_o];
        for (int w = 0; w < 2; w++) begin
            if (tg[sram_addr_o][w][24] && tg[sram_addr_o][w][22:0] == cpu_addr_i[31:9]) begin
                sram_hit_i = 1'b1;
                sram_way   = w[0];
            end
        end
        sram_tag_i  = tg[sram_addr_o][sram_way];
        sram_data_i = dt[sram_addr_o][sram_way];
    end

    // SRAM update: writes land in the hit way or the victim way; any access makes the other way LRU
    always @(posedge clk_i) begin
        if (sram_enable_o === 1'b1 && (sram_write_o === 1'b1 || sram_hit_i)) begin
            if (sram_write_o === 1'b1) begin
                tg[sram_addr_o][sram_way] <= sram_tag_o;
                dt[sram_addr_o][sram_way] <= sram_data_o;
            end
            lru[sram_addr_o] <= ~sram_way;
        end
    end

    // Memory model: acks mem_lat cycles after a request appears, checks the request stays stable
    initial begin
        int cnt;
        int stray_seen;
        logic [31:0]  c_addr;
        logic         c_wr;
        logic [255:0] c_dat;
        cnt = -1;
        stray_seen = 0;
        c_addr = '0;
        c_wr = 1'b0;
        c_dat = '0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                mem_ack_i = 1'b1;
                cnt = -1;
            end else if (!rst_i || mem_enable_o !== 1'b1) begin
                cnt = -1;
            end else begin
                if (cnt < 0) begin
                    c_addr = mem_addr_o;
                    c_wr   = mem_write_o;
                    c_dat  = mem_data_o;
                    mlog.push_back('{c_addr, c_wr});
                    cnt = 0;
                    if (c_wr) chk("wb_data", c_dat, ref_line(c_addr));
                end else begin
                    chk("mem_hold", {mem_enable_o, mem_write_o, mem_addr_o, mem_data_o},
                        {1'b1, c_wr, c_addr, c_dat});
                    chk("stall_during_mem", cpu_stall_o, 1'b1);
                end
                if (cnt >= mem_lat) begin
                    mem_ack_i = 1'b1;
                    if (c_wr) bmem[c_addr >> 5] = c_dat;
                    else mem_data_i = mem_line(c_addr);
                    cnt = -1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: every completed request is matched against the oldest expectation
    initial begin
        exp_t e;
        logic [255:0] l;
        forever begin
            @(negedge clk_i);
            if (rst_i && (cpu_MemRead_i || cpu_MemWrite_i) && cpu_stall_o === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion addr=%0h", cpu_addr_i);
                end else begin
                    e = sb.pop_front();
                    chk("req_addr", cpu_addr_i, e.addr);
                    if (e.st) begin
                        l = sram_data_o;
                        chk("store_write", sram_write_o, 1'b1);
                        chk("store_tag", sram_tag_o, {2'b11, e.addr[31:9]});
                        chk("store_word", l[int'(e.addr[4:2])*32 +: 32], e.data);
                    end else begin
                        chk("load_data", cpu_data_o, e.data);
                        chk("load_nowrite", sram_write_o, 1'b0);
                    end
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input bit st, input bit both, input logic [31:0] wd);
        int exp_stall;
        int nstall;
        bit done;
        exp_stall = predict(a);
        @(posedge clk_i); #1;
        cpu_addr_i     = a;
        cpu_data_i     = wd;
        cpu_MemWrite_i = st;
        cpu_MemRead_i  = !st || both;
        if (st) begin
            sb.push_back('{1'b1, a, wd});
            ref_mem[a >> 2] = wd;
        end else begin
            sb.push_back('{1'b0, a, ref_word(a)});
        end
        nstall = 0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_i);
            if (cpu_stall_o === 1'b0) done = 1'b1;
            else nstall++;
        end
        chk("req_done", done, 1'b1);
        chk("stall_cycles", nstall, exp_stall);
        @(posedge clk_i); #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic chk_last_txn(input string nm, input int back, input logic [31:0] a, input logic wr);
        chk({nm, "_present"}, mlog.size() > back, 1'b1);
        if (mlog.size() > back) begin
            chk({nm, "_addr"}, mlog[mlog.size()-1-back].addr, a);
            chk({nm, "_wr"}, mlog[mlog.size()-1-back].wr, wr);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [31:0] a;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mem_enable", mem_enable_o, 1'b0);
        chk("rst_mem_write", mem_write_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 256'h0);
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_data", cpu_data_o, 32'h0);

        // Cold miss with clean victim, refill supplies 0xDEADBEEF at word 0
        mem_lat = 2;
        poke_word(32'h400, 32'hDEAD_BEEF);
        do_req(32'h400, 1'b0, 1'b0, '0);
        chk_last_txn("cold_refill", 0, 32'h400, 1'b0);

        // Store hit on the resident line, then read it back
        do_req(32'h404, 1'b1, 1'b0, 32'h1234_5678);
        do_req(32'h404, 1'b0, 1'b0, '0);

        // Conflict sequence in set 0 ending in a dirty write-back of 0x000 and refill of 0x400
        do_req(32'h000, 1'b0, 1'b0, '0);
        do_req(32'h000, 1'b1, 1'b0, 32'hCAFE_0001);
        do_req(32'h200, 1'b0, 1'b0, '0);
        do_req(32'h400, 1'b0, 1'b0, '0);
        chk_last_txn("dirty_wb", 1, 32'h000, 1'b1);
        chk_last_txn("dirty_refill", 0, 32'h400, 1'b0);

        // Slow memory on set 15
        mem_lat = 10;
        do_req(32'h1E4, 1'b0, 1'b0, '0);
        chk_last_txn("slow_refill", 0, 32'h1E0, 1'b0);

        // Reset while waiting for the refill, then a stray ack
        mem_lat = 30;
        @(posedge clk_i); #1;
        cpu_addr_i    = 32'h0E0;
        cpu_MemRead_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (mem_enable_o === 1'b1 && mem_write_o === 1'b0) found = 1'b1;
        end
        chk("reach_readmiss", found, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        chk("abort_mem_enable", mem_enable_o, 1'b0);
        chk("abort_mem_addr", mem_addr_o, 32'h0);
        cpu_MemRead_i = 1'b0;
        #1 chk("abort_stall", cpu_stall_o, 1'b0);
        @(posedge clk_i); #1 rst_i = 1'b1;
        stray_req++;
        repeat (3) @(negedge clk_i);
        chk("stray_mem_enable", mem_enable_o, 1'b0);
        chk("stray_stall", cpu_stall_o, 1'b0);
        mem_lat = 2;
        do_req(32'h0E0, 1'b0, 1'b0, '0);
        chk_last_txn("remiss", 0, 32'h0E0, 1'b0);

        // Read and write together on a resident line behaves as a store
        do_req(32'h408, 1'b1, 1'b1, 32'hA5A5_5A5A);
        do_req(32'h408, 1'b0, 1'b0, '0);

        // Random traffic over a small conflicting address pool
        for (int n = 0; n < 300; n++) begin
            logic [31:0] tag;
            logic [31:0] idx;
            tag = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       idx = 0;
                1:       idx = 3;
                default: idx = 15;
            endcase
            a = (tag << 9) | (idx << 5) | (32'($urandom_range(0, 7)) << 2);
            mem_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                do_req(a, 1'b1, $urandom_range(0, 3) == 0, $urandom);
            else
                do_req(a, 1'b0, 1'b0, '0);
        end

        repeat (4) @(negedge clk_i);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Controls a 2-way set-associative, write-back, write-allocate data cache.
- Sits between the CPU memory stage and the 16-set dcache tag/data SRAM.
- Serves hits combinationally and stalls the CPU on a miss.
- On a miss, writes back a dirty victim and refills the line from the 256-bit memory port.

Parameters:
TAG_W, 23, address tag bits (addr[31:9])
IDX_W, 4, set index bits (addr[8:5]); 16 sets
LINE_W, 256, cache line bits (32 bytes)
WORD_W, 32, CPU word bits; word select = addr[4:2]

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
cpu_addr_i  in  32  CPU byte address
cpu_data_i  in  32  CPU store data
cpu_MemRead_i  in  1  load request
cpu_MemWrite_i  in  1  store request
cpu_data_o  out  32  load data
cpu_stall_o  out  1  CPU must hold request
sram_addr_o  out  4  SRAM set index
sram_tag_o  out  25  {valid, dirty, tag[22:0]} to write
sram_data_o  out  256  line to write
sram_enable_o  out  1  SRAM access enable
sram_write_o  out  1  SRAM write strobe
sram_tag_i  in  25  hit tag, or LRU victim tag on miss
sram_data_i  in  256  hit line, or LRU victim line on miss
sram_hit_i  in  1  tag match in either way
mem_addr_o  out  32  line-aligned memory address
mem_data_o  out  256  write-back line
mem_enable_o  out  1  memory request, level
mem_write_o  out  1  1 = write-back, 0 = refill
mem_data_i  in  256  refill line
mem_ack_i  in  1  one-cycle completion

Behaviour:
Reset and request:
- rst_i low (async) forces state IDLE and clears the registered outputs mem_enable_o, mem_write_o, mem_addr_o and mem_data_o to 0.
- req = cpu_MemRead_i | cpu_MemWrite_i. If both are asserted, the request is treated as a write.
- sram_addr_o = cpu_addr_i[8:5]. sram_enable_o = req.
- The SRAM contract: the tag field compared against is tag[22:0]; tag bit 24 is valid and bit 23 is dirty.

Stall and load data:
- cpu_stall_o = req & ~(state==IDLE & sram_hit_i). It is combinational.
- cpu_data_o = word addr[4:2] of sram_data_i when req & hit & IDLE, else 0.

IDLE:
- Read hit: zero-cycle latency, no SRAM write.
- Write hit: sram_write_o=1 that cycle.
  - sram_data_o = sram_data_i with word addr[4:2] replaced by cpu_data_i.
  - sram_tag_o = {1,1,addr[31:9]}.
- Miss (req & ~hit): go to MISS.
- mem_ack_i is ignored.

MISS (1 cycle):
- If sram_tag_i[24] & sram_tag_i[23], the victim is dirty. Register:
  - mem_enable_o=1, mem_write_o=1
  - mem_addr_o={sram_tag_i[22:0], idx, 5'b0}
  - mem_data_o=sram_data_i
  - then go to WRITEBACK.
- Otherwise register mem_enable_o=1, mem_write_o=0, mem_addr_o={addr[31:9], idx, 5'b0}, then go to READMISS.

WRITEBACK:
- Hold all mem outputs stable.
- On mem_ack_i: mem_write_o=0, mem_addr_o = refill address, mem_enable_o stays 1; go to READMISS.

READMISS:
- Hold the request.
- On mem_ack_i:
  - mem_enable_o=0
  - sram_write_o=1, sram_data_o=mem_data_i, sram_tag_o={1,0,addr[31:9]} (same cycle, combinational)
  - go to READMISSOK.

READMISSOK (1 cycle):
- No SRAM write. Go to IDLE.
- The held request then hits; a store is merged and marked dirty by the write-hit path.

Latency:
- Clean miss: 2 + mem latency + 2 cycles before the hit cycle.
- Dirty miss: adds one full memory transaction.

Boundaries:
- mem_ack_i outside WRITEBACK/READMISS is ignored.
- The CPU must hold its address and data while stalled; changes are undefined.
- Reset mid-transaction abandons it. A late ack after reset is ignored.
- mem_enable_o never deasserts between issue and ack.
- Index wrap: sets 0 and 15 behave identically.

Decomposition:
- Shared package dcache_pkg holds:
  - state enum: IDLE, MISS, WRITEBACK, READMISS, READMISSOK
  - field widths TAG_W, IDX_W, LINE_W, WORD_W
  - tag bit positions VALID_BIT=24, DIRTY_BIT=23
- Optional sub-module dcache_word_merge: combinational 32-into-256 word insert/extract, reused by the SRAM write path.

Test Plan:
- Load 0x0000_0400 after reset (cold miss, clean victim) -> mem_write_o=0 read of 0x400; after ack with line word0=0xDEADBEEF, stall drops and cpu_data_o=0xDEADBEEF.
- Store 0x1234_5678 to 0x404 on a resident line -> single-cycle write, no stall, sram_tag_o={1,1,tag}, word1 updated; next load 0x404 returns 0x12345678.
- Fill both ways of set 0 via 0x000 and 0x200, dirty the way at 0x000, then load 0x400 -> write-back to mem_addr_o=0x000 with dirty data, then refill from 0x400.
- Memory ack delayed 10 cycles -> mem_enable_o, mem_addr_o and mem_data_o stable for all 10; cpu_stall_o high throughout.
- Assert rst_i low during READMISS -> state IDLE, mem_enable_o=0 immediately; a subsequent stray mem_ack_i is ignored and the next request misses anew.
- Simultaneous MemRead & MemWrite hit at 0x408 -> treated as a store (sram_write_o=1, dirty set).
